// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler
//   Round-robin front end that shares one pipelined multiplier among N_REQ
//   requesters. One operation is issued per cycle at most. Each issued
//   operation's requester ID travels down a tag pipeline that matches the
//   multiplier latency. The product is then returned on a tagged response bus.
//   A hold input drives a RUN/DRAIN/HALT FSM so that software can stop issue
//   and wait until the pipeline is empty.
//
// Handshake: a request from requester i is accepted at a rising edge where
//   req_valid[i] & req_ready[i] = 1. req_ready is a pure function of
//   req_valid, hold, FSM state and the round-robin pointer, and never of
//   itself. Responses have no back-pressure: resp_valid is a one-cycle strobe.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   hold                stop issuing; FSM drains and then halts
//   mul_a/mul_b         operands to the multiplier (zero when not issuing)
//   mul_ena/mul_enb     multiplier operand-register loads
//   mul_p               product from the multiplier, MUL_LAT edges after load
//   resp_valid/id/p     registered tagged response
//   idle                registered: FSM is in HALT (pipeline empty)
//   issue_cnt           wrapping count of issued operations
//   dbg_state           current FSM state, for debug and checkers

module mult_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic                     hold,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_ena,
  output logic                     mul_enb,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [2*WIDTH-1:0]       resp_p,
  output logic                     idle,
  output logic [15:0]              issue_cnt,
  output logic [1:0]               dbg_state
);

  localparam int LAST = MUL_LAT - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MUL_LAT-1:0]  tag_v_q, tag_v_d;
  logic [ID_W-1:0]     tag_id_q [MUL_LAT];
  logic [ID_W-1:0]     tag_id_d [MUL_LAT];
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [2*WIDTH-1:0]  resp_p_q, resp_p_d;
  logic                idle_q, idle_d;
  logic [15:0]         issue_cnt_q, issue_cnt_d;

  logic [WIDTH-1:0]    op_a [N_REQ];
  logic [WIDTH-1:0]    op_b [N_REQ];
  logic                issue_ok;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     arb_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Issue is gated by reset as well so that nothing leaks out while rst_n is low.
  assign issue_ok = rst_n && (state_q == ST_RUN) && !hold;

  // The scan runs from the farthest candidate back toward the pointer. The
  // last hit therefore wins, and it is the first requester at or after the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      arb_idx = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
      if (req_valid[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx;
      end
    end
    grant_vld = grant_vld & issue_ok;
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (grant_vld) begin
      req_ready = N_REQ'(1) << grant_id;
      mul_a     = op_a[grant_id];
      mul_b     = op_b[grant_id];
    end
  end

  assign mul_ena = grant_vld;
  assign mul_enb = grant_vld;

  // Datapath next-state: pointer, tag shift register, response, counter.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end

    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = grant_vld;
    tag_id_d[0] = grant_id;
    for (int j = 1; j < MUL_LAT; j++) begin
      tag_v_d[j]  = tag_v_q[j-1];
      tag_id_d[j] = tag_id_q[j-1];
    end

    // The last tag stage lines up with mul_p. The response registers keep
    // their old values on cycles that carry no result.
    resp_valid_d = tag_v_q[LAST];
    resp_id_d    = resp_id_q;
    resp_p_d     = resp_p_q;
    if (tag_v_q[LAST]) begin
      resp_id_d = tag_id_q[LAST];
      resp_p_d  = mul_p;
    end

    issue_cnt_d = issue_cnt_q + {15'd0, grant_vld};
  end

  // FSM next-state. Dropping hold always returns to RUN, and any in-flight
  // tags keep moving, so a DRAIN that is abandoned loses nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (hold) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!hold)         state_d = ST_RUN;
        else if (~|tag_v_q) state_d = ST_HALT;
      end
      ST_HALT:  if (!hold) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    idle_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      rr_ptr_q     <= '0;
      tag_v_q      <= '0;
      for (int j = 0; j < MUL_LAT; j++) tag_id_q[j] <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_p_q     <= '0;
      idle_q       <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_p_q     <= resp_p_d;
      idle_q       <= idle_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_p     = resp_p_q;
  assign idle       = idle_q;
  assign issue_cnt  = issue_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
module tb_mult_rr_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int L   = 2;
  localparam int IDW = 2;
  localparam int EW  = IDW + 2*W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic             hold;
  logic [W-1:0]     mul_a, mul_b;
  logic             mul_ena, mul_enb;
  logic [2*W-1:0]   mul_p;
  logic             resp_valid;
  logic [IDW-1:0]   resp_id;
  logic [2*W-1:0]   resp_p;
  logic             idle;
  logic [15:0]      issue_cnt;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  mult_rr_scheduler #(.N_REQ(N), .WIDTH(W), .MUL_LAT(L), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .hold(hold),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ena(mul_ena), .mul_enb(mul_enb),
    .mul_p(mul_p),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_p(resp_p),
    .idle(idle), .issue_cnt(issue_cnt), .dbg_state(dbg_state)
  );

  // Multiplier environment: the product appears L edges after operand load.
  logic [2*W-1:0] p_pipe [L];
  always @(posedge clk) begin
    p_pipe[0] <= mul_ena ? (2*W)'(mul_a) * (2*W)'(mul_b) : '0;
    for (int j = 1; j < L; j++) p_pipe[j] <= p_pipe[j-1];
  end
  assign mul_p = p_pipe[L-1];

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected responses: {id, product}, with the edge number at which each is due.
  logic [EW-1:0]  exp_q [$];
  int             due_q [$];
  logic [EW-1:0]  got_q [$];
  bit             log_en = 1'b0;

  int             m_ptr = 0;
  int             m_state = 0;        // 0 run, 1 drain, 2 halt
  logic [15:0]    m_cnt = '0;
  logic           m_idle = 1'b0;
  logic           m_rv = 1'b0;
  logic [IDW-1:0] m_rid = '0;
  logic [2*W-1:0] m_rp = '0;
  int             cyc = 0;

  initial begin : model_proc
    bit             hs;
    int             hid;
    logic [W-1:0]   ea, eb;
    logic [2*W-1:0] prod;
    logic           rst_s, hold_s;
    bit             busy;
    @(posedge clk);  // first edge is a reset edge; model starts in reset values
    forever begin
      @(negedge clk);
      hs = 1'b0; hid = 0; ea = '0; eb = '0;
      if (rst_n && m_state == 0 && !hold) begin
        for (int off = 0; off < N; off++) begin
          if (!hs && req_valid[(m_ptr + off) % N]) begin
            hs  = 1'b1;
            hid = (m_ptr + off) % N;
          end
        end
      end
      if (hs) begin
        ea = req_a[hid*W +: W];
        eb = req_b[hid*W +: W];
      end
      prod = (2*W)'(ea) * (2*W)'(eb);
      chk("req_ready", req_ready, hs ? (N'(1) << hid) : N'(0));
      chk("mul_a", mul_a, ea);
      chk("mul_b", mul_b, eb);
      chk("mul_ena", mul_ena, hs);
      chk("mul_enb", mul_enb, hs);
      chk("resp_valid", resp_valid, m_rv);
      chk("resp_id", resp_id, m_rid);
      chk("resp_p", resp_p, m_rp);
      chk("idle", idle, m_idle);
      chk("issue_cnt", issue_cnt, m_cnt);
      if (log_en && resp_valid) got_q.push_back({resp_id, resp_p});
      rst_s  = rst_n;
      hold_s = hold;

      @(posedge clk);
      cyc++;
      if (!rst_s) begin
        exp_q.delete(); due_q.delete();
        m_ptr = 0; m_cnt = '0; m_state = 0; m_idle = 1'b0;
        m_rv = 1'b0; m_rid = '0; m_rp = '0;
      end else begin
        busy = (exp_q.size() != 0);
        case (m_state)
          0: if (hold_s) m_state = 1;
          1: if (!hold_s) m_state = 0; else if (!busy) m_state = 2;
          default: if (!hold_s) m_state = 0;
        endcase
        m_idle = (m_state == 2);
        m_rv = 1'b0;
        if (due_q.size() != 0 && due_q[0] == cyc) begin
          m_rv = 1'b1;
          {m_rid, m_rp} = exp_q.pop_front();
          void'(due_q.pop_front());
        end
        if (hs) begin
          exp_q.push_back({IDW'(hid), prod});
          due_q.push_back(cyc + L);
          m_ptr = (hid + 1) % N;
          m_cnt = m_cnt + 16'd1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; hold = 1'b0;
    step();
    rst_n = 1'b1;
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main_proc
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; hold = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #2;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_issue_cnt", issue_cnt, 16'd0);
    chk("rst_idle", idle, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    log_en = 1'b1;

    // Single request from requester 0: 5*3.
    do_reset();
    set_op(0, 8'd5, 8'd3); req_valid = 4'b0001;
    #2 chk("t1_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    chk("t1_no_resp_yet", resp_valid, 1'b0);
    step();
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_resp_id", resp_id, 2'd0);
    chk("t1_resp_p", resp_p, 16'd15);
    repeat (3) step();
    chk("t1_count", got_q.size(), 1);
    chk("t1_issue_cnt", issue_cnt, 16'd1);

    // All four requesters valid for eight cycles.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 8'd10);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #2 chk("t2_grant", req_ready, 4'b0001 << (c % 4));
      step();
    end
    req_valid = '0;
    repeat (4) step();
    chk("t2_count", got_q.size(), 8);
    for (int c = 0; c < 8 && c < got_q.size(); c++)
      chk("t2_resp", got_q[c], {2'(c % 4), 16'((c % 4 + 1) * 10)});

    // Largest operands, back-to-back from two requesters.
    do_reset();
    set_op(2, 8'd255, 8'd255); req_valid = 4'b0100;
    step();
    set_op(3, 8'd255, 8'd2); req_valid = 4'b1000;
    step();
    req_valid = '0;
    repeat (4) step();
    chk("t3_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t3_resp0", got_q[0], {2'd2, 16'd65025});
      chk("t3_resp1", got_q[1], {2'd3, 16'd510});
    end

    // Hold and drain, then resume from the pointer.
    do_reset();
    set_op(0, 8'd3, 8'd4); set_op(1, 8'd6, 8'd7);
    set_op(2, 8'd9, 8'd9); set_op(3, 8'd1, 8'd1);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1111; hold = 1'b1;
    #2 chk("t4_hold_ready", req_ready, 4'b0000);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t4_hold_ready", req_ready, 4'b0000);
    end
    chk("t4_idle", idle, 1'b1);
    chk("t4_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t4_resp0", got_q[0], {2'd0, 16'd12});
      chk("t4_resp1", got_q[1], {2'd1, 16'd42});
    end
    hold = 1'b0;
    #2 chk("t4_release_ready", req_ready, 4'b0000);
    step();
    #2 chk("t4_resume_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    repeat (4) step();

    // Reset with an operation in flight.
    do_reset();
    set_op(0, 8'd10, 8'd10); req_valid = 4'b0001;
    step();
    req_valid = '0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("t5_no_resp", got_q.size(), 0);
    chk("t5_issue_cnt", issue_cnt, 16'd0);
    chk("t5_idle", idle, 1'b0);
    req_valid = 4'b1111;
    #2 chk("t5_ptr_zero", req_ready, 4'b0001);
    step();
    req_valid = '0;
    repeat (4) step();

    // Randomised traffic with hold bursts and occasional resets.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_a = (N*W)'($urandom);
      req_b = (N*W)'($urandom);
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1; hold = 1'b0; req_valid = '0;
    repeat (4) step();

    // issue_cnt wrap after 65536 operations.
    log_en = 1'b0;
    do_reset();
    req_valid = 4'b1111;
    repeat (65535) step();
    req_valid = '0;
    #2 chk("t6_cnt_max", issue_cnt, 16'hFFFF);
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    #2 chk("t6_cnt_wrap", issue_cnt, 16'h0000);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Round-robin scheduler that shares one pipelined adder-tree multiplier among N_REQ requesters.
- Each requester hands over an operand pair with a valid/ready handshake. The scheduler issues at most one operation per cycle and tracks requester IDs through the multiplier latency.
- It returns each product on a shared tagged response bus. A hold/drain FSM lets software stop issue and wait for the pipeline to empty.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product width is 2*WIDTH.
- MUL_LAT, 2, posedges from operand capture until mul_p is valid (≥1).
- ID_W, 2, requester ID width (= clog2(N_REQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant; one-hot or zero.
- req_a  in  N_REQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing.
- hold  in  1  stop issuing new operations.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_ena  out  1  multiplier A-register load.
- mul_enb  out  1  multiplier B-register load.
- mul_p  in  2*WIDTH  product from the multiplier.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  ID_W  requester ID of the response.
- resp_p  out  2*WIDTH  product.
- idle  out  1  FSM in HALT and pipeline empty.
- issue_cnt  out  16  total issued operations; wraps 0xFFFF→0.

Behaviour:
- Reset (rst_n low at posedge) clears the following, and all in-flight tags are discarded (no response is ever produced for them):
  - resp_valid=0, resp_id=0, resp_p=0, issue_cnt=0, rr pointer=0, tag pipeline cleared, FSM=RUN.
  - While rst_n is low: req_ready=0, mul_ena=mul_enb=0, mul_a=mul_b=0.
- FSM states:
  - RUN: issue allowed.
  - DRAIN: hold=1, no issue, in-flight ops complete.
  - HALT: hold=1 and pipeline empty.
- FSM transitions:
  - RUN→DRAIN when hold=1.
  - DRAIN→HALT when no tag valid in the pipeline.
  - DRAIN or HALT→RUN when hold=0; a DRAIN→RUN return keeps in-flight ops.
- Outputs per state:
  - idle=1 only in HALT, registered.
  - hold is sampled combinationally for issue: if hold=1 in RUN, no grant is made in that cycle.
- Arbitration is combinational, in RUN with hold=0:
  - Grant the first i with req_valid[i]=1, searching from the rr pointer upward modulo N_REQ.
  - req_ready[i]=1 for the granted i only; req_ready never depends on req_ready.
- Issue: on a grant, mul_a/mul_b are driven with that requester's operands and mul_ena=mul_enb=1 in the same cycle. The handshake completes at the posedge where req_valid[i]&req_ready[i]=1.
- Idle drive: with no grant, mul_ena=mul_enb=0 and mul_a=mul_b=0.
- Pointer update: after a handshake with requester i, the pointer becomes (i+1) mod N_REQ. With no handshake the pointer is unchanged.
- Tag pipeline: a shift register MUL_LAT deep of {valid, id}, advancing every cycle. A handshake at posedge k produces the response registered at posedge k+MUL_LAT:
  - resp_valid=1 for exactly the cycle after that edge;
  - resp_p=mul_p, resp_id=granted id.
- Throughput and ordering:
  - Throughput is one op per cycle; responses return in issue order.
  - There is no response back-pressure: consumers must accept resp_valid every cycle.
- resp_p and resp_id hold their last value when resp_valid=0.
- issue_cnt increments on each handshake and wraps.
- Widths: the scheduler does not compute products; resp_p is mul_p unmodified (max (2^WIDTH−1)^2 fits 2*WIDTH).
- Simultaneous events:
  - hold rising in the same cycle as req_valid: no grant.
  - A requester dropping req_valid before it is granted: no effect on the others.

Test Plan:
- Req0 sends a=5, b=3 alone → req_ready[0]=1 the same cycle; resp_valid=1 with resp_id=0, resp_p=15 at MUL_LAT=2 edges later; issue_cnt=1.
- All 4 requesters held valid (a=i+1, b=10) for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses 10,20,30,40 repeating, back-to-back, ids in order.
- Req2 sends 255*255 then req3 sends 255*2 on the next cycle → responses 65025 (id 2) then 510 (id 3) on consecutive cycles.
- Issue 2 ops, assert hold next cycle with all req_valid=1 → no further req_ready; both responses arrive; idle=1 the cycle after drain; release hold → issue resumes from the pointer after the last grant.
- Issue 10*10, pull rst_n low for 1 cycle at the following edge → no resp_valid for that op; issue_cnt=0, pointer=0, FSM=RUN after reset.
- Preload issue_cnt to 0xFFFF via 65535 ops (or force), issue 1 more → issue_cnt=0.
